// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus an FSM-driven iterative shift-add multiply.
// Defining EXE_DIV_EN adds unsigned restoring divide on EXE_CMD 1101 (quotient; /0 gives all ones).
module exe_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        EXE_CMD,
    input  logic [DATA_W-1:0] val1,
    input  logic [DATA_W-1:0] val2,
    input  logic [DATA_W-1:0] reg2,
    input  logic [4:0]        dest,
    input  logic              WB_EN,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    output logic              stall,
    output logic              WB_En_EXE,
    output logic [1:0]        MEM_Signal_EXE,
    output logic [4:0]        dest_EXE,
    output logic [DATA_W-1:0] ALU_result_EXE,
    output logic [DATA_W-1:0] reg2_EXE
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0100;
    localparam logic [3:0] CMD_OR  = 4'b0101;
    localparam logic [3:0] CMD_NOR = 4'b0110;
    localparam logic [3:0] CMD_XOR = 4'b0111;
    localparam logic [3:0] CMD_SLL = 4'b1000;
    localparam logic [3:0] CMD_SRA = 4'b1001;
    localparam logic [3:0] CMD_SRL = 4'b1010;
    localparam logic [3:0] CMD_MUL = 4'b1100;
`ifdef EXE_DIV_EN
    localparam logic [3:0] CMD_DIV = 4'b1101;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    // r_opa: multiplicand (shifted left) or divisor; r_opb: multiplier (shifted right) or dividend/quotient
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic [DATA_W-1:0] r_acc;
    logic              w_multi;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_final;

`ifdef EXE_DIV_EN
    logic              r_is_div;
    logic [DATA_W:0]   w_rem_sh;
    logic              w_ge;
    assign w_multi  = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIV);
    assign w_rem_sh = {r_acc, r_opb[DATA_W-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_opa});
    assign w_final  = r_is_div ? r_opb : r_acc;
`else
    assign w_multi  = (EXE_CMD == CMD_MUL);
    assign w_final  = r_acc;
`endif

    assign stall = ~rst & in_valid & w_multi & (r_state != DONE);

    always_comb begin
        w_alu = '0;
        case (EXE_CMD)
            CMD_ADD: w_alu = val1 + val2;
            CMD_SUB: w_alu = val1 - val2;
            CMD_AND: w_alu = val1 & val2;
            CMD_OR:  w_alu = val1 | val2;
            CMD_NOR: w_alu = ~(val1 | val2);
            CMD_XOR: w_alu = val1 ^ val2;
            CMD_SLL: w_alu = val1 << val2[4:0];
            CMD_SRA: w_alu = $signed(val1) >>> val2[4:0];
            CMD_SRL: w_alu = val1 >> val2[4:0];
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_opa          <= '0;
            r_opb          <= '0;
            r_acc          <= '0;
`ifdef EXE_DIV_EN
            r_is_div       <= 1'b0;
`endif
            WB_En_EXE      <= 1'b0;
            MEM_Signal_EXE <= 2'b00;
            dest_EXE       <= '0;
            ALU_result_EXE <= '0;
            reg2_EXE       <= '0;
        end else begin
            // Bubble by default; only a completed instruction overrides it
            WB_En_EXE      <= 1'b0;
            MEM_Signal_EXE <= 2'b00;
            dest_EXE       <= '0;
            ALU_result_EXE <= '0;
            reg2_EXE       <= '0;
            case (r_state)
                IDLE: begin
                    if (in_valid && w_multi) begin
                        r_state <= RUN;
                        r_cnt   <= '0;
                        r_acc   <= '0;
`ifdef EXE_DIV_EN
                        r_is_div <= (EXE_CMD == CMD_DIV);
                        r_opa    <= (EXE_CMD == CMD_DIV) ? val2 : val1;
                        r_opb    <= (EXE_CMD == CMD_DIV) ? val1 : val2;
`else
                        r_opa   <= val1;
                        r_opb   <= val2;
`endif
                    end else if (in_valid) begin
                        WB_En_EXE      <= WB_EN;
                        MEM_Signal_EXE <= {MEM_R_EN, MEM_W_EN};
                        dest_EXE       <= dest;
                        ALU_result_EXE <= w_alu;
                        reg2_EXE       <= reg2;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_ITER)
                        r_state <= DONE;
`ifdef EXE_DIV_EN
                    if (r_is_div) begin
                        r_acc <= w_ge ? (w_rem_sh[DATA_W-1:0] - r_opa) : w_rem_sh[DATA_W-1:0];
                        r_opb <= {r_opb[DATA_W-2:0], w_ge};
                    end else
`endif
                    begin
                        if (r_opb[0])
                            r_acc <= r_acc + r_opa;
                        r_opa <= r_opa << 1;
                        r_opb <= r_opb >> 1;
                    end
                end
                DONE: begin
                    r_state        <= IDLE;
                    WB_En_EXE      <= WB_EN;
                    MEM_Signal_EXE <= {MEM_R_EN, MEM_W_EN};
                    dest_EXE       <= dest;
                    ALU_result_EXE <= w_final;
                    reg2_EXE       <= reg2;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exe_stage.sv
// Randomized self-checking bench for exe_stage against an arithmetic reference model.
module tb_exe_stage;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [3:0]        EXE_CMD;
    logic [DATA_W-1:0] val1, val2, reg2;
    logic [4:0]        dest;
    logic              WB_EN, MEM_R_EN, MEM_W_EN;
    logic              stall;
    logic              WB_En_EXE;
    logic [1:0]        MEM_Signal_EXE;
    logic [4:0]        dest_EXE;
    logic [DATA_W-1:0] ALU_result_EXE;
    logic [DATA_W-1:0] reg2_EXE;

    int n_vec = 0;
    int n_err = 0;

`ifdef EXE_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    exe_stage #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .EXE_CMD(EXE_CMD),
        .val1(val1), .val2(val2), .reg2(reg2), .dest(dest),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .stall(stall), .WB_En_EXE(WB_En_EXE), .MEM_Signal_EXE(MEM_Signal_EXE),
        .dest_EXE(dest_EXE), .ALU_result_EXE(ALU_result_EXE), .reg2_EXE(reg2_EXE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_multi(input logic [3:0] cmd);
        return (cmd == 4'b1100) || (DIV_EN && cmd == 4'b1101);
    endfunction

    function automatic logic [31:0] model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int unsigned sh;
        sh = b % 32;
        case (cmd)
            4'b0000: return a + b;
            4'b0010: return a - b;
            4'b0100: return a & b;
            4'b0101: return a | b;
            4'b0110: return ~(a | b);
            4'b0111: return a ^ b;
            4'b1000: return a << sh;
            4'b1001: return (a >> sh) | ((a[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'b1010: return a >> sh;
            4'b1100: begin prod = 64'(a) * 64'(b); return prod[31:0]; end
            4'b1101: return !DIV_EN ? 32'h0 : (b == 0 ? 32'hFFFF_FFFF : a / b);
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_wb"},   32'(WB_En_EXE), 32'h0);
        check({tag, "_mem"},  32'(MEM_Signal_EXE), 32'h0);
        check({tag, "_dest"}, 32'(dest_EXE), 32'h0);
        check({tag, "_res"},  ALU_result_EXE, 32'h0);
        check({tag, "_reg2"}, reg2_EXE, 32'h0);
        check({tag, "_stall"}, 32'(stall), 32'h0);
    endtask

    task automatic run_op(input string tag, input logic v, input logic [3:0] cmd,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] r2,
                          input logic [4:0] d, input logic wb, input logic mr, input logic mw);
        logic [31:0] exp_res;
        int n;
        exp_res = model(cmd, a, b);
        @(negedge clk);
        in_valid = v; EXE_CMD = cmd; val1 = a; val2 = b; reg2 = r2;
        dest = d; WB_EN = wb; MEM_R_EN = mr; MEM_W_EN = mw;
        #1;
        if (v && is_multi(cmd)) begin
            check({tag, "_stall_rise"}, 32'(stall), 32'h1);
            n = 0;
            while (stall === 1'b1 && n < 200) begin
                @(posedge clk); #1;
                check({tag, "_bubble"}, {31'h0, WB_En_EXE} | ALU_result_EXE, 32'h0);
                n++;
            end
            check({tag, "_stall_cycles"}, 32'(n), 32'(DATA_W + 1));
        end else begin
            check({tag, "_nostall"}, 32'(stall), 32'h0);
        end
        @(posedge clk); #1;
        if (!v) begin
            check_zero_outputs({tag, "_bub"});
        end else begin
            check({tag, "_res"},  ALU_result_EXE, exp_res);
            check({tag, "_wb"},   32'(WB_En_EXE), 32'(wb));
            check({tag, "_mem"},  32'(MEM_Signal_EXE), 32'({mr, mw}));
            check({tag, "_dest"}, 32'(dest_EXE), 32'(d));
            check({tag, "_reg2"}, reg2_EXE, r2);
        end
        $display("op %-8s v=%0d cmd=%b a=%08h b=%08h -> res=%08h exp=%08h", tag, v, cmd, a, b, ALU_result_EXE, v ? exp_res : 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; EXE_CMD = '0; val1 = '0; val2 = '0; reg2 = '0;
        dest = '0; WB_EN = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk); rst = 1'b0;

        run_op("add",   1, 4'b0000, 32'd5, 32'd7, 32'h0, 5'd3, 1, 0, 0);
        run_op("load",  1, 4'b0000, 32'd1024, 32'd8, 32'h0, 5'd9, 1, 1, 0);
        run_op("store", 1, 4'b0000, 32'd1024, 32'd8, 32'hDEAD, 5'd0, 0, 0, 1);
        run_op("sra",   1, 4'b1001, 32'h8000_0000, 32'd4, 32'h0, 5'd1, 1, 0, 0);
        run_op("srl",   1, 4'b1010, 32'h8000_0000, 32'd4, 32'h0, 5'd1, 1, 0, 0);
        run_op("mul1",  1, 4'b1100, 32'h0001_0001, 32'h0000_FFFF, 32'h0, 5'd4, 1, 0, 0);
        run_op("mul2",  1, 4'b1100, 32'd3, 32'd4, 32'h0, 5'd5, 1, 0, 0);
        run_op("div1",  1, 4'b1101, 32'd100, 32'd7, 32'h0, 5'd6, 1, 0, 0);
        run_op("div0",  1, 4'b1101, 32'h1234_5678, 32'd0, 32'h0, 5'd7, 1, 0, 0);
        run_op("bubble", 0, 4'b0000, 32'h55, 32'h66, 32'h77, 5'd8, 1, 1, 1);

        // Abort a multiply at RUN iteration 10 with reset
        @(negedge clk);
        in_valid = 1'b1; EXE_CMD = 4'b1100; val1 = 32'd9; val2 = 32'd9; dest = 5'd2; WB_EN = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check_zero_outputs("abort");
        @(negedge clk); rst = 1'b0;
        run_op("post_add", 1, 4'b0000, 32'd1, 32'd1, 32'h0, 5'd2, 1, 0, 0);
        run_op("post_mul", 1, 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 5'd2, 1, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_op("rand", ($urandom_range(0, 7) != 0), c, a, b, $urandom,
                   5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
